sequence_acquisition_nslot: RTL and testbench
=============================================

// Module: sequence_acquisition_nslot
// PURPOSE
//  Parametrised auto-zero acquisition sequencer; sits between the register bank and the AZ mux,
//  pre-charge switch and ADC. Cycles through up to NSLOTS programmable (azmux, pc) slots.
//  Per slot: boot pc switch, settle azmux, select pc, then start the ADC and wait for its result.
//  Extends the fixed 2-sample hi/lo sequencer with a programmable slot table and slot count.
//  Adds ground-slot pc skip and an optional ADC timeout.
// PARAMETERS
//  NSLOTS    8   max slots in table (2..8)
//  AZMUX_W   4   azmux code width
//  PC_W      2   pre-charge switch code width
//  CNT_W     24  dwell/timeout counter width
// PORTS
//  clk                      in   1              system clock; all state on posedge
//  reset_n                  in   1              async active-low reset
//  p_clk_count_precharge_i  in   CNT_W          dwell count per settle phase
//  p_nslots_i               in   3              active slots minus 1 (0 => 1 slot)
//  p_seq_azmux_i            in   NSLOTS*AZMUX_W slot k azmux code at [k*AZMUX_W +: AZMUX_W]
//  p_seq_pc_i               in   NSLOTS*PC_W    slot k pc code at [k*PC_W +: PC_W]; 0 = ground slot
//  adc_measure_valid_i      in   1              ADC result ready (level, sampled in MEASURE only)
//  adc_reset_no             out  1              0 = ADC held in reset, 1 = ADC measuring
//  sw_pc_ctl_o              out  PC_W           pre-charge switch control
//  azmux_o                  out  AZMUX_W        AZ mux select
//  led0_o                   out  1              toggles once per slot
//  status_o                 out  4              {seq_wrap, slot[2:0]} of last completed slot
//  slot_o                   out  3              slot currently in progress
//  monitor_o                out  8              [3:0] one-hot slot 0..3, [5:4] sw_pc_ctl_o, [6] adc_reset_no, [7] adc_measure_valid_i
// BEHAVIOUR
//  Reset values (async, immediate): state=IDLE, all outputs 0, slot=0, counter=0, table latches=0.
//  States:
//  - IDLE: adc_reset_no<=0 -> ARM. Entered only from reset.
//  - ARM:
//    - sw_pc_ctl_o<=0 (boot); led0_o toggles; counter<=precharge.
//    - Latches slot azmux/pc codes from the table -> WAIT_BOOT.
//    - At slot 0, also latches n=min(p_nslots_i, NSLOTS-1) and the whole table.
//      Changes mid-sequence take effect at the next wrap.
//  - WAIT_BOOT: counter==0 -> AZ.
//  - AZ: azmux_o<=slot code; counter<=precharge -> WAIT_AZ.
//  - WAIT_AZ: counter==0 -> PC.
//  - PC: sw_pc_ctl_o<=slot pc code; counter<=precharge.
//    - pc code 0 (ground slot): adc_reset_no<=1 -> MEASURE; WAIT_PC skipped.
//    - otherwise -> WAIT_PC.
//  - WAIT_PC: counter==0 -> adc_reset_no<=1 -> MEASURE.
//  - MEASURE: on adc_measure_valid_i=1:
//    - adc_reset_no<=0.
//    - status_o<={slot==n, slot}.
//    - slot<=(slot==n)?0:slot+1.
//    - -> ARM.
//  Dwell: counter decrements every cycle; each WAIT_* lasts precharge+1 cycles (precharge=0 -> 1 cycle).
//  adc_measure_valid_i outside MEASURE is ignored; valid held high is not double-counted (one slot per MEASURE entry).
//  status_o changes only at MEASURE completion so software reads it during the next slot.
//  azmux_o holds its value through ARM/WAIT_BOOT; it changes only in AZ.
//  Counter width CNT_W; loaded value zero-extended, no wrap below 0 (exits at 0).
// CONFIGURATION
//  SEQ_ACQ_TIMEOUT_EN defined:
//  - Adds input p_clk_count_timeout_i[CNT_W] and output err_timeout_o (reset 0, sticky until reset_n).
//  - On MEASURE entry, counter<=timeout.
//  - If counter reaches 0 before valid: adc_reset_no<=0, err_timeout_o<=1, status_o unchanged;
//    slot advances as if measured -> ARM.
//  SEQ_ACQ_TIMEOUT_EN undefined:
//  - No extra ports; MEASURE waits indefinitely for valid.
// TESTING
//  1 Reset: reset_n=0 mid-WAIT_AZ -> same cycle all outputs 0; release -> IDLE, ARM, azmux_o=0 until AZ.
//  2 Slot sequence, setup:
//    - p_nslots_i=2, precharge=5.
//    - azmux {S3,S7,S1}, pc {01,00,10}; ADC valid 3 cycles after start.
//  2 Slot sequence, required response:
//    - azmux_o sequence S3,S7,S1,S3...
//    - WAIT phases 6 cycles each; slot1 has no WAIT_PC; led0_o toggles per slot.
//    - status_o 0x0,0x1,0xA.
//  3 precharge=0, p_nslots_i=0 -> single slot repeats; each WAIT 1 cycle; slot_o stays 0; status_o=0x8.
//  4 valid pulsed in WAIT_AZ -> ignored, no slot advance.
//    valid held high across MEASURE entries -> exactly one advance per MEASURE.
//  5 p_nslots_i changed 1->3 during slot1 of 2 -> current sequence wraps after slot1; next runs 4 slots.
//  6 (SEQ_ACQ_TIMEOUT_EN) timeout=10, valid never -> 11 cycles in MEASURE, err_timeout_o=1, slot advances, status_o unchanged.

Source files
------------

// File: rtl/sequence_acquisition_nslot.sv
// sequence_acquisition_nslot: N-slot auto-zero acquisition sequencer driving AZ mux, pre-charge switch and ADC reset.
// Optional ADC timeout and sticky error flag are enabled by defining SEQ_ACQ_TIMEOUT_EN.
module sequence_acquisition_nslot #(
  parameter int NSLOTS  = 8,
  parameter int AZMUX_W = 4,
  parameter int PC_W    = 2,
  parameter int CNT_W   = 24
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [CNT_W-1:0]          p_clk_count_precharge_i,
  input  logic [2:0]                p_nslots_i,
  input  logic [NSLOTS*AZMUX_W-1:0] p_seq_azmux_i,
  input  logic [NSLOTS*PC_W-1:0]    p_seq_pc_i,
  input  logic                      adc_measure_valid_i,
`ifdef SEQ_ACQ_TIMEOUT_EN
  input  logic [CNT_W-1:0]          p_clk_count_timeout_i,
  output logic                      err_timeout_o,
`endif
  output logic                      adc_reset_no,
  output logic [PC_W-1:0]           sw_pc_ctl_o,
  output logic [AZMUX_W-1:0]        azmux_o,
  output logic                      led0_o,
  output logic [3:0]                status_o,
  output logic [2:0]                slot_o,
  output logic [7:0]                monitor_o
);
  typedef enum logic [2:0] {IDLE, ARM, WAIT_BOOT, AZ, WAIT_AZ, PC, WAIT_PC, MEASURE} state_t;
  localparam logic [2:0] N_MAX = 3'(NSLOTS - 1);
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt, meas_ld;
  logic [2:0] n;
  logic [NSLOTS*AZMUX_W-1:0] tbl_az, az_src;
  logic [NSLOTS*PC_W-1:0] tbl_pc, pc_src;
  logic [AZMUX_W-1:0] az_code;
  logic [PC_W-1:0] pc_code;
  logic cnt_done, last, timed_out, done;
  // slot 0 reads the live table because that is the cycle the snapshot is taken
  assign az_src = (slot_o == 3'd0) ? p_seq_azmux_i : tbl_az;
  assign pc_src = (slot_o == 3'd0) ? p_seq_pc_i : tbl_pc;
  assign cnt_done = (cnt == '0);
  assign last = (slot_o == n);
`ifdef SEQ_ACQ_TIMEOUT_EN
  assign meas_ld = p_clk_count_timeout_i;
  assign timed_out = cnt_done;
`else
  assign meas_ld = p_clk_count_precharge_i;
  assign timed_out = 1'b0;
`endif
  assign done = adc_measure_valid_i | timed_out;
  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  end
  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      state_nx = ARM;
      ARM:       state_nx = WAIT_BOOT;
      WAIT_BOOT: state_nx = cnt_done ? AZ : WAIT_BOOT;
      AZ:        state_nx = WAIT_AZ;
      WAIT_AZ:   state_nx = cnt_done ? PC : WAIT_AZ;
      PC:        state_nx = (pc_code == '0) ? MEASURE : WAIT_PC;
      WAIT_PC:   state_nx = cnt_done ? MEASURE : WAIT_PC;
      MEASURE:   state_nx = done ? ARM : MEASURE;
      default:   state_nx = IDLE;
    endcase
  end
  // registered outputs, dwell counter and slot table snapshot
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      n <= '0;
      tbl_az <= '0;
      tbl_pc <= '0;
      az_code <= '0;
      pc_code <= '0;
      adc_reset_no <= 1'b0;
      sw_pc_ctl_o <= '0;
      azmux_o <= '0;
      led0_o <= 1'b0;
      status_o <= '0;
      slot_o <= '0;
`ifdef SEQ_ACQ_TIMEOUT_EN
      err_timeout_o <= 1'b0;
`endif
    end else begin
      cnt <= cnt_done ? cnt : cnt - 1'b1;
      case (state)
        IDLE: adc_reset_no <= 1'b0;
        ARM: begin
          sw_pc_ctl_o <= '0;
          led0_o <= ~led0_o;
          cnt <= p_clk_count_precharge_i;
          az_code <= az_src[int'(slot_o)*AZMUX_W +: AZMUX_W];
          pc_code <= pc_src[int'(slot_o)*PC_W +: PC_W];
          if (slot_o == 3'd0) begin
            n <= (p_nslots_i > N_MAX) ? N_MAX : p_nslots_i;
            tbl_az <= p_seq_azmux_i;
            tbl_pc <= p_seq_pc_i;
          end
        end
        AZ: begin
          azmux_o <= az_code;
          cnt <= p_clk_count_precharge_i;
        end
        PC: begin
          sw_pc_ctl_o <= pc_code;
          cnt <= (pc_code == '0) ? meas_ld : p_clk_count_precharge_i;
          if (pc_code == '0) adc_reset_no <= 1'b1;
        end
        WAIT_PC: if (cnt_done) begin
          adc_reset_no <= 1'b1;
          cnt <= meas_ld;
        end
        MEASURE: if (done) begin
          adc_reset_no <= 1'b0;
          slot_o <= last ? 3'd0 : slot_o + 3'd1;
          if (adc_measure_valid_i) status_o <= {last, slot_o};
`ifdef SEQ_ACQ_TIMEOUT_EN
          if (!adc_measure_valid_i) err_timeout_o <= 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end
  // debug monitor bus
  always_comb begin
    monitor_o = {adc_measure_valid_i, adc_reset_no, 2'(sw_pc_ctl_o), slot_o[2] ? 4'b0000 : 4'b0001 << slot_o[1:0]};
  end
endmodule

// File: tb/tb_sequence_acquisition_nslot.sv
// tb_sequence_acquisition_nslot: directed bench with a per-slot timeline model of the sequencer
`timescale 1ns/1ps
module tb_sequence_acquisition_nslot;
  localparam int NS = 8;
  localparam int BIG = 1 << 30;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [23:0] pre = '0;
  logic [2:0] nsl = '0;
  logic [31:0] taz = '0;
  logic [15:0] tpc = '0;
  logic valid = 1'b0;
  logic adc_reset_no;
  logic [1:0] sw;
  logic [3:0] az;
  logic led;
  logic [3:0] status;
  logic [2:0] slot;
  logic [7:0] mon;
`ifdef SEQ_ACQ_TIMEOUT_EN
  logic [23:0] tmo = '0;
  logic err;
`endif
  always #5 clk = ~clk;
  sequence_acquisition_nslot dut (
    .clk(clk),
    .reset_n(reset_n),
    .p_clk_count_precharge_i(pre),
    .p_nslots_i(nsl),
    .p_seq_azmux_i(taz),
    .p_seq_pc_i(tpc),
    .adc_measure_valid_i(valid),
`ifdef SEQ_ACQ_TIMEOUT_EN
    .p_clk_count_timeout_i(tmo),
    .err_timeout_o(err),
`endif
    .adc_reset_no(adc_reset_no),
    .sw_pc_ctl_o(sw),
    .azmux_o(az),
    .led0_o(led),
    .status_o(status),
    .slot_o(slot),
    .monitor_o(mon)
  );
  int pass_cnt = 0;
  int tot_cnt = 0;
  function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
    tot_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endfunction
  function automatic int qat(int q[$], int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction
  // timeline model: per slot, compute the cycles at which each output changes
  int c, a, m, azt, pct, errt, s, mn, pp, vmode, vdly;
  logic vspur, pend, pend_to, v;
  logic [3:0] lat_az [NS];
  logic [1:0] lat_pc [NS];
  logic [3:0] code_az;
  logic [1:0] code_pc;
  logic e_adc, e_led, e_err;
  logic [1:0] e_sw;
  logic [3:0] e_az, e_status;
  logic [2:0] e_slot;
  logic [6:0] e_mon;
  logic l_led, l_adc;
  logic [3:0] l_az;
  int led_q[$], st_q[$], sl_q[$], adc_q[$], fall_q[$], az_q[$];
  task automatic model_reset();
    c = 0; a = 1; m = BIG; azt = BIG; pct = BIG; errt = BIG; s = 0; mn = 0;
    pend = 0; pend_to = 0; code_az = 0; code_pc = 0;
    e_adc = 0; e_led = 0; e_err = 0; e_sw = 0; e_az = 0; e_status = 0; e_slot = 0;
    l_led = 0; l_adc = 0; l_az = 0;
    led_q.delete(); st_q.delete(); sl_q.delete(); adc_q.delete(); fall_q.delete(); az_q.delete();
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask
  task automatic run_cycles(int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      if (c == a) begin
        if (pend) begin
          e_adc = 0;
          if (!pend_to) e_status = {s == mn, 3'(s)};
          s = (s == mn) ? 0 : s + 1;
          e_slot = 3'(s);
          pend = 0;
        end
        if (s == 0) begin
          mn = (int'(nsl) > NS - 1) ? NS - 1 : int'(nsl);
          for (int k = 0; k < NS; k++) begin
            lat_az[k] = taz[k*4 +: 4];
            lat_pc[k] = tpc[k*2 +: 2];
          end
        end
        code_az = lat_az[s];
        code_pc = lat_pc[s];
        pp = int'(pre);
        azt = a + pp + 3;
        pct = a + 2*pp + 5;
        m = (code_pc != 0) ? a + 3*pp + 6 : a + 2*pp + 5;
      end
      if (c == a + 1) begin
        e_led = ~e_led;
        e_sw = 0;
      end
      if (c == azt) e_az = code_az;
      if (c == pct) e_sw = code_pc;
      if (c == m) e_adc = 1;
      if (c == errt) e_err = 1;
      e_mon = {e_adc, e_sw, (e_slot < 4) ? 4'(1 << e_slot) : 4'b0000};
      chk("adc_reset_no", adc_reset_no, e_adc);
      chk("sw_pc_ctl", sw, e_sw);
      chk("azmux", az, e_az);
      chk("led0", led, e_led);
      chk("status", status, e_status);
      chk("slot", slot, e_slot);
      chk("monitor", mon[6:0], e_mon);
`ifdef SEQ_ACQ_TIMEOUT_EN
      chk("err_timeout", err, e_err);
`endif
      if (led !== l_led) begin led_q.push_back(c); st_q.push_back(int'(status)); sl_q.push_back(int'(slot)); end
      if (adc_reset_no && !l_adc) adc_q.push_back(c);
      if (!adc_reset_no && l_adc) fall_q.push_back(c);
      if (az !== l_az) az_q.push_back(int'(az));
      l_led = led; l_adc = adc_reset_no; l_az = az;
      v = (vmode == 1) || (vmode == 0 && c == m + vdly) || (vspur && c == azt);
      valid = v;
      if (!pend && c >= m && v) begin
        pend = 1; pend_to = 0; a = c + 1;
      end
`ifdef SEQ_ACQ_TIMEOUT_EN
      else if (!pend && c >= m && c == m + int'(tmo)) begin
        pend = 1; pend_to = 1; a = c + 1; errt = c + 1;
      end
`endif
      @(negedge clk);
      c++;
    end
  endtask
  initial begin
    vmode = 0; vdly = 3; vspur = 0;
    pre = 24'd5; nsl = 3'd2; taz = 32'h0000_0173; tpc = 16'h0021;
    do_reset();
    run_cycles(12);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async_adc", adc_reset_no, 0);
    chk("rst_async_az", az, 0);
    chk("rst_async_sw", sw, 0);
    chk("rst_async_led", led, 0);
    chk("rst_async_status", status, 0);
    chk("rst_async_mon", mon[6:0], 7'h01);
    do_reset();
    run_cycles(80);
    chk("t2_adc_rise0", qat(adc_q, 0), 22);
    chk("t2_adc_rise1", qat(adc_q, 1), 41);
    chk("t2_adc_rise2", qat(adc_q, 2), 66);
    chk("t2_az0", qat(az_q, 0), 3);
    chk("t2_az1", qat(az_q, 1), 7);
    chk("t2_az2", qat(az_q, 2), 1);
    chk("t2_az3", qat(az_q, 3), 3);
    chk("t2_st1", qat(st_q, 1), 0);
    chk("t2_st2", qat(st_q, 2), 1);
    chk("t2_st3", qat(st_q, 3), 10);
    pre = 24'd0; nsl = 3'd0;
    do_reset();
    run_cycles(40);
    chk("t3_led0", qat(led_q, 0), 2);
    chk("t3_led1", qat(led_q, 1), 12);
    chk("t3_led3", qat(led_q, 3), 32);
    chk("t3_status", status, 8);
    chk("t3_slot", slot, 0);
    pre = 24'd1; nsl = 3'd2; vspur = 1;
    do_reset();
    run_cycles(30);
    chk("t4_spur_led1", qat(led_q, 1), 15);
    vspur = 0; vmode = 1;
    do_reset();
    run_cycles(45);
    chk("t4_held_led1", qat(led_q, 1), 12);
    chk("t4_held_led2", qat(led_q, 2), 20);
    chk("t4_held_led3", qat(led_q, 3), 30);
    chk("t4_held_led4", qat(led_q, 4), 40);
    vmode = 0; nsl = 3'd1; taz = 32'h0000_9173; tpc = 16'h00E1;
    do_reset();
    run_cycles(20);
    nsl = 3'd3;
    run_cycles(62);
    for (int k = 0; k < 7; k++) begin
      int exp_sl [7] = '{0, 1, 0, 1, 2, 3, 0};
      chk($sformatf("t5_slot%0d", k), qat(sl_q, k), exp_sl[k]);
    end
    chk("t5_st_wrap1", qat(st_q, 2), 9);
    chk("t5_st_wrap2", qat(st_q, 6), 11);
`ifdef SEQ_ACQ_TIMEOUT_EN
    vmode = 2; tmo = 24'd10; nsl = 3'd1;
    do_reset();
    run_cycles(30);
    chk("t6_rise", qat(adc_q, 0), 10);
    chk("t6_fall", qat(fall_q, 0), 21);
    chk("t6_err", err, 1);
    chk("t6_status", status, 0);
    chk("t6_slot", slot, 1);
`endif
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
